// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues in-order imem requests against a 2-deep credit pool
// and buffers returned words with their PCs in a 2-entry FIFO for the decode stage.
//
// state    | meaning
// ST_RUN   | no stale responses pending, every response is kept
// ST_DRAIN | kill > 0, the next kill responses belong to a pre-redirect path
module instr_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid
);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [1:0]  out_cnt_q, out_cnt_d;
    logic [1:0]  kill_q, kill_d;
    logic [1:0]  occ_q, occ_d;
    logic [31:0] rq_pc0_q, rq_pc0_d;
    logic [31:0] rq_pc1_q, rq_pc1_d;
    logic [31:0] fifo_pc0_q, fifo_pc0_d;
    logic [31:0] fifo_w0_q, fifo_w0_d;
    logic [31:0] fifo_pc1_q, fifo_pc1_d;
    logic [31:0] fifo_w1_q, fifo_w1_d;

    logic        head_valid;
    logic        pop;
    logic        resp_take;
    logic        resp_drop;
    logic        resp_keep;
    logic        accept;
    logic [1:0]  out_after_resp;
    logic [1:0]  occ_after_pop;
    logic [2:0]  credit_used;

    always_comb begin
        head_valid     = (occ_q != 2'd0) && !rst;
        pop            = head_valid && !stall;
        resp_take      = imem_resp_valid && (out_cnt_q != 2'd0);
        out_after_resp = out_cnt_q - {1'b0, resp_take};
        credit_used    = {1'b0, out_cnt_q} + {1'b0, occ_q} - {2'b00, pop};
        accept         = imem_req_valid && imem_req_ready;
        resp_keep      = resp_take && !resp_drop;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; kill is reloaded (never accumulated) on every redirect
    always_comb begin
        kill_d = kill_q;
        if (redirect) begin
            kill_d = out_after_resp;
        end else if (resp_take && (state_q == ST_DRAIN)) begin
            kill_d = kill_q - 2'd1;
        end
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (kill_d != 2'd0) state_d = ST_DRAIN;
            ST_DRAIN: if (kill_d == 2'd0) state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    // Output logic
    always_comb begin
        imem_req_valid = !rst && !redirect && (credit_used < 3'd2);
        imem_req_addr  = fetch_pc_q;
        resp_drop      = redirect || (state_q == ST_DRAIN);
        instr_valid    = head_valid;
        instr          = head_valid ? fifo_w0_q  : NOP_INSTR;
        instr_pc       = head_valid ? fifo_pc0_q : 32'h0000_0000;
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (redirect) begin
            fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
        end else if (accept) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end

        // PCs of outstanding requests, oldest in slot 0, matched to in-order responses
        rq_pc0_d = rq_pc0_q;
        rq_pc1_d = rq_pc1_q;
        if (resp_take) begin
            rq_pc0_d = rq_pc1_q;
        end
        if (accept) begin
            if (out_after_resp == 2'd0) begin
                rq_pc0_d = fetch_pc_q;
            end else begin
                rq_pc1_d = fetch_pc_q;
            end
        end
        out_cnt_d = out_after_resp + {1'b0, accept};

        fifo_pc0_d    = fifo_pc0_q;
        fifo_w0_d     = fifo_w0_q;
        fifo_pc1_d    = fifo_pc1_q;
        fifo_w1_d     = fifo_w1_q;
        occ_after_pop = occ_q - {1'b0, pop};
        if (pop) begin
            fifo_pc0_d = fifo_pc1_q;
            fifo_w0_d  = fifo_w1_q;
        end
        if (resp_keep) begin
            if (occ_after_pop == 2'd0) begin
                fifo_pc0_d = rq_pc0_q;
                fifo_w0_d  = imem_resp_data;
            end else begin
                fifo_pc1_d = rq_pc0_q;
                fifo_w1_d  = imem_resp_data;
            end
        end
        occ_d = occ_after_pop + {1'b0, resp_keep};
        if (redirect) begin
            occ_d = 2'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            out_cnt_q  <= 2'd0;
            kill_q     <= 2'd0;
            occ_q      <= 2'd0;
            rq_pc0_q   <= 32'h0000_0000;
            rq_pc1_q   <= 32'h0000_0000;
            fifo_pc0_q <= 32'h0000_0000;
            fifo_w0_q  <= 32'h0000_0000;
            fifo_pc1_q <= 32'h0000_0000;
            fifo_w1_q  <= 32'h0000_0000;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            out_cnt_q  <= out_cnt_d;
            kill_q     <= kill_d;
            occ_q      <= occ_d;
            rq_pc0_q   <= rq_pc0_d;
            rq_pc1_q   <= rq_pc1_d;
            fifo_pc0_q <= fifo_pc0_d;
            fifo_w0_q  <= fifo_w0_d;
            fifo_pc1_q <= fifo_pc1_d;
            fifo_w1_q  <= fifo_w1_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a queue-based imem model with 1-cycle latency,
// response hold / ready throttling, and hand-computed per-cycle expectations.
module tb_instr_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = 32'h0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        stall = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;

    logic        mem_ready = 1'b1;
    logic        mem_hold = 1'b0;
    logic        mem_spur = 1'b0;
    logic [31:0] mq[$];

    int n_chk = 0;
    int n_fail = 0;

    assign imem_req_ready = mem_ready;

    instr_fetch #(
        .RESET_PC (32'h0000_0000),
        .NOP_INSTR(NOP)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_valid    (instr_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5C3_0F00;
    endfunction

    // Memory answers one cycle after acceptance, in order
    always @(negedge clk) begin
        if (mq.size() > 0 && !mem_hold) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(mq[0]);
        end else if (mem_spur) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = 32'hDEAD_BEEF;
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = 32'h0;
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
        end else begin
            if (imem_resp_valid && mq.size() > 0) void'(mq.pop_front());
            if (imem_req_valid && imem_req_ready) mq.push_back(imem_req_addr);
        end
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic exp_instr(input string tag, input logic v, input logic [31:0] pc);
        check_val({tag, "_valid"}, {31'h0, instr_valid}, {31'h0, v});
        check_val({tag, "_pc"}, instr_pc, v ? pc : 32'h0);
        check_val({tag, "_instr"}, instr, v ? mem_word(pc) : NOP);
    endtask

    task automatic exp_req(input string tag, input logic v, input logic [31:0] addr);
        check_val({tag, "_req_valid"}, {31'h0, imem_req_valid}, {31'h0, v});
        if (v) check_val({tag, "_req_addr"}, imem_req_addr, addr);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset held
        repeat (3) next_cycle();
        #1;
        exp_req("rst", 1'b0, 32'h0);
        exp_instr("rst", 1'b0, 32'h0);

        // release: first request at RESET_PC, instr visible two cycles later
        next_cycle(); rst = 1'b0; #1;
        exp_req("c1", 1'b1, 32'h0);
        exp_instr("c1", 1'b0, 32'h0);
        next_cycle(); #1;
        exp_req("c2", 1'b1, 32'h4);
        exp_instr("c2_nobypass", 1'b0, 32'h0);
        next_cycle(); #1;
        exp_req("c3", 1'b1, 32'h8);
        exp_instr("c3", 1'b1, 32'h0);
        next_cycle(); #1;
        exp_instr("c4", 1'b1, 32'h4);

        // stall for 5 cycles: head frozen, FIFO fills, credit exhausted
        next_cycle(); stall = 1'b1; #1;
        exp_instr("stall0", 1'b1, 32'h8);
        exp_req("stall0", 1'b0, 32'h0);
        for (int i = 6; i <= 9; i++) begin
            next_cycle();
            mem_spur = (i == 7);
            #1;
            exp_instr("stall_hold", 1'b1, 32'h8);
            exp_req("stall_hold", 1'b0, 32'h0);
        end
        next_cycle(); stall = 1'b0; mem_spur = 1'b0; #1;
        exp_instr("unstall0", 1'b1, 32'h8);
        exp_req("unstall0", 1'b1, 32'h10);
        next_cycle(); #1;
        exp_instr("unstall1", 1'b1, 32'hC);
        exp_req("unstall1", 1'b1, 32'h14);
        next_cycle(); #1;
        exp_instr("unstall2", 1'b1, 32'h10);

        // hold responses so two requests are outstanding, then redirect
        next_cycle(); mem_hold = 1'b1; #1;
        exp_instr("hold0", 1'b1, 32'h14);
        exp_req("hold0", 1'b1, 32'h1C);
        next_cycle(); #1;
        exp_instr("hold1", 1'b0, 32'h0);
        exp_req("hold1", 1'b0, 32'h0);
        next_cycle(); redirect = 1'b1; redirect_pc = 32'h0000_0102; #1;
        exp_req("redir", 1'b0, 32'h0);
        next_cycle(); redirect = 1'b0; mem_hold = 1'b0; #1;
        exp_instr("kill0", 1'b0, 32'h0);
        exp_req("kill0", 1'b0, 32'h0);
        next_cycle(); #1;
        exp_instr("kill1", 1'b0, 32'h0);
        exp_req("kill1", 1'b1, 32'h100);
        next_cycle(); #1;
        exp_instr("kill2", 1'b0, 32'h0);
        exp_req("kill2", 1'b1, 32'h104);
        next_cycle(); #1;
        exp_instr("newpath0", 1'b1, 32'h100);
        next_cycle(); #1;
        exp_instr("newpath1", 1'b1, 32'h104);

        // redirect together with a response and a stall
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0200; #1;
        exp_req("rs_redir", 1'b0, 32'h0);
        next_cycle(); stall = 1'b0; redirect = 1'b0; #1;
        exp_instr("rs_flush", 1'b0, 32'h0);
        exp_req("rs_flush", 1'b1, 32'h200);
        next_cycle(); #1;
        exp_instr("rs1", 1'b0, 32'h0);
        exp_req("rs1", 1'b1, 32'h204);
        next_cycle(); #1;
        exp_instr("rs2", 1'b1, 32'h200);

        // redirect with credit available, low bits masked, address wrap
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFB; #1;
        exp_req("wr_redir", 1'b0, 32'h0);
        next_cycle(); redirect = 1'b0; #1;
        exp_instr("wr0", 1'b0, 32'h0);
        exp_req("wr0", 1'b1, 32'hFFFF_FFF8);
        next_cycle(); #1;
        exp_req("wr1", 1'b1, 32'hFFFF_FFFC);
        next_cycle(); #1;
        exp_req("wr2_wrap", 1'b1, 32'h0);
        exp_instr("wr2", 1'b1, 32'hFFFF_FFF8);
        next_cycle(); #1;
        exp_instr("wr3", 1'b1, 32'hFFFF_FFFC);
        exp_req("wr3", 1'b1, 32'h4);
        next_cycle(); #1;
        exp_instr("wr4", 1'b1, 32'h0);

        // ready low: address must hold
        mem_ready = 1'b0; #1;
        exp_req("rdy0", 1'b1, 32'h8);
        next_cycle(); #1;
        exp_instr("rdy1", 1'b1, 32'h4);
        exp_req("rdy1", 1'b1, 32'h8);
        next_cycle(); mem_ready = 1'b1; #1;
        exp_instr("rdy2", 1'b0, 32'h0);
        exp_req("rdy2", 1'b1, 32'h8);
        next_cycle(); #1;
        exp_req("rdy3", 1'b1, 32'hC);
        next_cycle(); #1;
        exp_instr("rdy4", 1'b1, 32'h8);

        // fill FIFO, then reset mid-operation
        stall = 1'b1;
        next_cycle(); #1;
        exp_instr("full", 1'b1, 32'h8);
        exp_req("full", 1'b0, 32'h0);
        next_cycle(); rst = 1'b1; #1;
        exp_instr("mrst0", 1'b0, 32'h0);
        exp_req("mrst0", 1'b0, 32'h0);
        next_cycle(); #1;
        exp_instr("mrst1", 1'b0, 32'h0);
        exp_req("mrst1", 1'b0, 32'h0);
        next_cycle(); rst = 1'b0; stall = 1'b0; #1;
        exp_req("rs_c1", 1'b1, 32'h0);
        exp_instr("rs_c1", 1'b0, 32'h0);
        next_cycle(); #1;
        exp_req("rs_c2", 1'b1, 32'h4);
        next_cycle(); #1;
        exp_instr("rs_c3", 1'b1, 32'h0);
        next_cycle(); #1;
        exp_instr("rs_c4", 1'b1, 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
